// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Define ALU_SHARE_FIXED_PRIO_EN to make requester 0 win whenever both request.
module alu_share_ctrl #(
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned OTHER_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [2:0]  req0_op_i,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [2:0]  req1_op_i,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_zero_i,
  output logic        resp_valid_o,
  output logic        resp_id_o,
  output logic [31:0] resp_data_o,
  output logic        resp_zero_o,
  input  logic        resp_ready_i,
  output logic        busy_o
);
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_UNDEF = 3'b111;
  localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);
  localparam logic [3:0] OTH_CNT  = 4'(OTHER_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        last_grant_q;
  logic [2:0]  op_q;
  logic [31:0] d1_q, d2_q;
  logic        id_q, undef_q;

  logic        grant0, grant1, accept;
  logic [2:0]  win_op;
  logic [31:0] win_d1, win_d2;

  always_comb begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
    grant1 = req1_valid_i && !req0_valid_i;
`else
    // last_grant resets to 1, so requester 0 wins the first contended cycle
    grant1 = req1_valid_i && (!req0_valid_i || !last_grant_q);
`endif
    grant0 = req0_valid_i && !grant1;
    req0_ready_o = (state_q == IDLE) && !rst_i && grant0;
    req1_ready_o = (state_q == IDLE) && !rst_i && grant1;
    accept = req0_ready_o || req1_ready_o;
    win_op = grant1 ? req1_op_i    : req0_op_i;
    win_d1 = grant1 ? req1_data1_i : req0_data1_i;
    win_d2 = grant1 ? req1_data2_i : req0_data2_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      op_q         <= 3'b000;
      d1_q         <= 32'd0;
      d2_q         <= 32'd0;
      id_q         <= 1'b0;
      undef_q      <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_id_o    <= 1'b0;
      resp_data_o  <= 32'd0;
      resp_zero_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant1;
        id_q         <= grant1;
        undef_q      <= (win_op == OP_UNDEF);
        // undefined op runs as 0+0 so the ALU never sees an unknown code
        op_q  <= (win_op == OP_UNDEF) ? 3'b000 : win_op;
        d1_q  <= (win_op == OP_UNDEF) ? 32'd0 : win_d1;
        d2_q  <= (win_op == OP_UNDEF) ? 32'd0 : win_d2;
        cnt_q <= (win_op == OP_MUL) ? MUL_CNT : OTH_CNT;
      end
      if (state_q == EXEC) begin
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          resp_valid_o <= 1'b1;
          resp_id_o    <= id_q;
          resp_data_o  <= undef_q ? 32'd0 : alu_data_i;
          resp_zero_o  <= undef_q ? 1'b1  : alu_zero_i;
        end
      end
      if (state_q == RESP && resp_ready_i) resp_valid_o <= 1'b0;
    end
  end

  assign alu_data1_o = d1_q;
  assign alu_data2_o = d2_q;
  assign alu_ctrl_o  = op_q;
  assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed table-driven bench for alu_share_ctrl with a simple ALU model attached.
module tb_alu_share_ctrl;
`ifdef ALU_SHARE_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic        clk_i = 0, rst_i = 1;
  logic        req0_valid_i = 0, req1_valid_i = 0;
  logic        req0_ready_o, req1_ready_o;
  logic [2:0]  req0_op_i = 0, req1_op_i = 0;
  logic [31:0] req0_data1_i = 0, req0_data2_i = 0, req1_data1_i = 0, req1_data2_i = 0;
  logic [31:0] alu_data1_o, alu_data2_o, alu_data_i;
  logic [2:0]  alu_ctrl_o;
  logic        alu_zero_i;
  logic        resp_valid_o, resp_id_o, resp_zero_o, busy_o;
  logic [31:0] resp_data_o;
  logic        resp_ready_i = 1;

  int n_cmp = 0, n_err = 0;

  alu_share_ctrl #(.MUL_LAT(3), .OTHER_LAT(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i),
    .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o), .resp_data_o(resp_data_o),
    .resp_zero_o(resp_zero_o), .resp_ready_i(resp_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // stand-in for the shared ALU: add, sub, mul, and, or
  always_comb begin
    case (alu_ctrl_o)
      3'b000:  alu_data_i = alu_data1_o + alu_data2_o;
      3'b001:  alu_data_i = alu_data1_o - alu_data2_o;
      3'b010:  alu_data_i = alu_data1_o * alu_data2_o;
      3'b011:  alu_data_i = alu_data1_o & alu_data2_o;
      default: alu_data_i = alu_data1_o | alu_data2_o;
    endcase
    alu_zero_i = (alu_data_i == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // waits for resp_valid_o at negedges; returns cycles elapsed (0 on timeout)
  task automatic wait_resp(output int n);
    int k = 0;
    bit got = 0;
    while (k < 40 && !got) begin
      @(negedge clk_i);
      k++;
      if (resp_valid_o) got = 1;
    end
    chk("resp_timeout", {31'd0, got}, 32'd1);
    n = got ? k : 0;
  endtask

  typedef struct {
    logic v0; logic [2:0] op0; logic [31:0] a0, b0;
    logic v1; logic [2:0] op1; logic [31:0] a1, b1;
    logic exp_id; logic [31:0] exp_data; logic exp_zero; int exp_lat;
  } vec_t;

  vec_t vt[9];

  initial begin
    int n;
    bit stale;
    logic [2:0]  e_op;
    logic [31:0] e_d1, e_d2;

    // contended sub 9-9 after reset: 0,1,0,1 (all 0 with fixed priority)
    vt[0] = '{1, 3'b001, 9, 9, 1, 3'b001, 9, 9, 0, 0, 1, 1};
    vt[1] = '{1, 3'b001, 9, 9, 1, 3'b001, 9, 9, FP ? 1'b0 : 1'b1, 0, 1, 1};
    vt[2] = '{1, 3'b001, 9, 9, 1, 3'b001, 9, 9, 0, 0, 1, 1};
    vt[3] = '{1, 3'b001, 9, 9, 1, 3'b001, 9, 9, FP ? 1'b0 : 1'b1, 0, 1, 1};
    vt[4] = '{1, 3'b000, 5, 7, 0, 3'b000, 0, 0, 0, 12, 0, 1};
    vt[5] = '{0, 3'b000, 0, 0, 1, 3'b010, 6, 7, 1, 42, 0, 3};
    vt[6] = '{1, 3'b111, 32'h55, 3, 0, 3'b000, 0, 0, 0, 0, 1, 1};
    // last grant 0 -> requester 1 wins under round robin
    vt[7] = '{1, 3'b000, 1, 2, 1, 3'b001, 10, 4, FP ? 1'b0 : 1'b1, FP ? 32'd3 : 32'd6, 0, 1};
    vt[8] = '{1, 3'b010, 3, 5, 1, 3'b000, 100, 32'hFFFF_FF9C, 0, 15, 0, 3};

    // reset state, readies held low while reset is high
    req0_valid_i = 1; req1_valid_i = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready0", {31'd0, req0_ready_o}, 0);
    chk("rst_ready1", {31'd0, req1_ready_o}, 0);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_resp_id_zero", {30'd0, resp_id_o, resp_zero_o}, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_alu", alu_data1_o | alu_data2_o | {29'd0, alu_ctrl_o}, 0);
    req0_valid_i = 0; req1_valid_i = 0;
    rst_i = 0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      req0_valid_i = vt[i].v0; req0_op_i = vt[i].op0;
      req0_data1_i = vt[i].a0; req0_data2_i = vt[i].b0;
      req1_valid_i = vt[i].v1; req1_op_i = vt[i].op1;
      req1_data1_i = vt[i].a1; req1_data2_i = vt[i].b1;
      #1;
      chk($sformatf("v%0d_ready0", i), {31'd0, req0_ready_o}, {31'd0, !vt[i].exp_id});
      chk($sformatf("v%0d_ready1", i), {31'd0, req1_ready_o}, {31'd0, vt[i].exp_id});
      e_op = vt[i].exp_id ? vt[i].op1 : vt[i].op0;
      e_d1 = vt[i].exp_id ? vt[i].a1 : vt[i].a0;
      e_d2 = vt[i].exp_id ? vt[i].b1 : vt[i].b0;
      if (e_op == 3'b111) begin e_op = 0; e_d1 = 0; e_d2 = 0; end
      @(posedge clk_i); #1;
      req0_valid_i = 0; req1_valid_i = 0;
      wait_resp(n);
      chk($sformatf("v%0d_latency", i), n, vt[i].exp_lat + 1);
      chk($sformatf("v%0d_data", i), resp_data_o, vt[i].exp_data);
      chk($sformatf("v%0d_zero", i), {31'd0, resp_zero_o}, {31'd0, vt[i].exp_zero});
      chk($sformatf("v%0d_id", i), {31'd0, resp_id_o}, {31'd0, vt[i].exp_id});
      chk($sformatf("v%0d_alu_ctrl", i), {29'd0, alu_ctrl_o}, {29'd0, e_op});
      chk($sformatf("v%0d_alu_d1", i), alu_data1_o, e_d1);
      chk($sformatf("v%0d_alu_d2", i), alu_data2_o, e_d2);
      chk($sformatf("v%0d_busy", i), {31'd0, busy_o}, 1);
    end

    // mul operand window: ctrl/operands stable on each EXEC cycle
    @(negedge clk_i);
    req1_valid_i = 1; req1_op_i = 3'b010; req1_data1_i = 6; req1_data2_i = 7;
    @(posedge clk_i); #1;
    req1_valid_i = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      chk($sformatf("mul_c%0d_ctrl", k), {29'd0, alu_ctrl_o}, 32'd2);
      chk($sformatf("mul_c%0d_ops", k), {alu_data1_o[15:0], alu_data2_o[15:0]}, {16'd6, 16'd7});
      chk($sformatf("mul_c%0d_valid", k), {31'd0, resp_valid_o}, 0);
    end
    @(negedge clk_i);
    chk("mul_c4_valid", {31'd0, resp_valid_o}, 1);
    chk("mul_c4_data", resp_data_o, 42);

    // response stall: everything held, no grants while busy
    @(negedge clk_i);
    resp_ready_i = 0;
    req0_valid_i = 1; req0_op_i = 3'b000; req0_data1_i = 2; req0_data2_i = 3;
    #1;
    chk("stall_accept", {31'd0, req0_ready_o}, 1);
    @(posedge clk_i); #1;
    req0_valid_i = 0;
    wait_resp(n);
    req1_valid_i = 1; req1_op_i = 3'b000; req1_data1_i = 1; req1_data2_i = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk($sformatf("stall%0d_resp", k), {resp_valid_o, resp_id_o, resp_zero_o, busy_o, resp_data_o[27:0]},
          {4'b1001, 28'd5});
      chk($sformatf("stall%0d_ready", k), {30'd0, req0_ready_o, req1_ready_o}, 0);
    end
    resp_ready_i = 1;
    @(negedge clk_i);
    chk("release_idle", {29'd0, resp_valid_o, busy_o, req1_ready_o}, 32'b001);
    @(posedge clk_i); #1;
    req1_valid_i = 0;
    wait_resp(n);
    chk("release_next", {resp_id_o, resp_data_o[30:0]}, {1'b1, 31'd2});

    // reset pulsed during a mul drops it
    @(negedge clk_i);
    req1_valid_i = 1; req1_op_i = 3'b010; req1_data1_i = 6; req1_data2_i = 7;
    @(posedge clk_i); #1;
    req1_valid_i = 0;
    @(negedge clk_i);
    chk("midrst_busy_before", {31'd0, busy_o}, 1);
    rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0;
    @(negedge clk_i);
    chk("midrst_state", {30'd0, resp_valid_o, busy_o}, 0);
    chk("midrst_alu", alu_data1_o | alu_data2_o | {29'd0, alu_ctrl_o}, 0);
    stale = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (resp_valid_o || busy_o) stale = 1;
    end
    chk("midrst_no_stale", {31'd0, stale}, 0);
    req0_valid_i = 1; req1_valid_i = 1;
    #1;
    chk("midrst_rr_restart", {30'd0, req0_ready_o, req1_ready_o}, 32'b10);
    req0_valid_i = 0; req1_valid_i = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one combinational ALU instance between two requesters (EX-stage operand path and an auxiliary address/branch unit).
- Provides round-robin arbitration with valid/ready handshakes on request and response sides.
- Holds ALU operands stable for a programmable multi-cycle multiply window.
- Registers the result and zero flag with the winning requester's ID until consumed.

Parameters:
- MUL_LAT, 3: ALU cycles allowed for op 3'b010 (mul); legal range 1..15.
- OTHER_LAT, 1: ALU cycles for every other op; legal range 1..15.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- req0_valid_i  input  1  requester 0 has an operation
- req0_ready_o  output  1  requester 0 operation accepted this cycle
- req0_op_i  input  3  ALU control code for requester 0
- req0_data1_i  input  32  operand 1, requester 0
- req0_data2_i  input  32  operand 2, requester 0
- req1_valid_i, req1_ready_o, req1_op_i, req1_data1_i, req1_data2_i: same as requester 0, for requester 1
- alu_data1_o  output  32  to ALU data1_i
- alu_data2_o  output  32  to ALU data2_i
- alu_ctrl_o  output  3  to ALU ALUCtrl_i
- alu_data_i  input  32  from ALU data_o
- alu_zero_i  input  1  from ALU Zero_o
- resp_valid_o  output  1  result available
- resp_id_o  output  1  requester that owns the result
- resp_data_o  output  32  registered ALU result
- resp_zero_o  output  1  registered zero flag
- resp_ready_i  input  1  consumer takes result
- busy_o  output  1  high in EXEC or RESP

Behaviour:
- Reset (rst_i high at a clk_i edge): state=IDLE, cnt=0, last_grant=1, operand/op regs=0, resp_valid_o=0, resp_id_o=0, resp_data_o=0, resp_zero_o=0. Both ready_o are held 0 while rst_i is high.
- Reset mid-operation: any in-flight or unconsumed result is dropped; no response is issued.
- State machine: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready_o is combinational and high only for the arbitration winner.
  - Only one requester is granted per cycle.
  - Neither ready_o is high when both valids are 0.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - last_grant updates only on acceptance.
- Accept (valid && ready at an edge):
  - Latch op, data1, data2 and the winner ID.
  - Load cnt = (op==3'b010 ? MUL_LAT : OTHER_LAT) - 1.
  - Go to EXEC.
- Opcode 3'b111 (undefined):
  - Accepted with latency OTHER_LAT.
  - Latched operands forced to 0 and op forced to 3'b000, so the ALU sees 0+0.
  - Response: resp_data_o=0, resp_zero_o=1.
- ALU drive: alu_*_o always come from the latched regs (0 after reset). They stay constant through EXEC and RESP and change only on an accept edge.
- EXEC:
  - cnt!=0: decrement.
  - cnt==0: capture alu_data_i into resp_data_o and alu_zero_i into resp_zero_o, set resp_valid_o=1 and resp_id_o=winner, go to RESP.
- Latency: accept edge at cycle 0 puts resp_valid_o high in cycle L+1 (L = op latency). Add 0 gives response in cycle 2; mul with MUL_LAT=3 gives cycle 4.
- RESP:
  - resp_* held stable while resp_ready_i=0 (no limit on stall length).
  - On resp_valid_o && resp_ready_i at an edge: resp_valid_o goes 0 and state goes to IDLE.
  - No new request is accepted in RESP or EXEC. Minimum issue interval is L+2 cycles.
- busy_o = (state != IDLE).
- Requester side rule: a requester must hold valid/op/data stable until ready; the controller does not check this.

Optional Feature:
- Macro ALU_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins when both are valid; last_grant is still maintained but ignored.
- Undefined: round-robin as above.

Test Plan:
- Only req0 valid, op=000, 5+7, resp_ready_i=1 -> req0_ready_o=1 in cycle 0; resp_valid_o=1 in cycle 2 with resp_data_o=12, resp_zero_o=0, resp_id_o=0.
- req0 and req1 both valid every cycle, op=001, 9-9 -> grants alternate 0,1,0,1 starting with 0 after reset; each response has data 0 and zero 1. With ALU_SHARE_FIXED_PRIO_EN, all grants go to 0.
- req1 op=010, 6*7, MUL_LAT=3 -> alu_ctrl_o=010 and operands stable for 3 cycles; resp_valid_o in cycle 4 with data 42 and id 1.
- resp_ready_i=0 for 5 cycles after a response -> resp_* stable, busy_o=1, both ready_o=0; release -> IDLE next cycle, next request accepted.
- rst_i pulsed in EXEC during a mul -> next cycle state IDLE, resp_valid_o=0, alu_*_o=0; no stale response afterwards.
- op=111 from req0 -> response in cycle 2 with data 0, zero 1; alu_ctrl_o=000.
